// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: gathers WIDTH strobed bits into one word and
// offers it through a single-entry valid/ready output slot with a sticky overrun flag.
module sipo_deserializer #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_in,
   input  logic             s_valid,
   output logic [WIDTH-1:0] p_out,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_pout;
   logic             r_pvalid;
   logic             r_ovr;

   logic [WIDTH-1:0] w_sh_next;
   logic             w_complete;
   logic             w_slot_free;

   always_comb begin
      w_sh_next = r_sh;
      if (MSB_FIRST) begin
         w_sh_next = {r_sh[WIDTH-2:0], s_in};
      end else begin
         w_sh_next = {s_in, r_sh[WIDTH-1:1]};
      end
   end

   // Completed word includes this cycle's bit, so it is taken from the next-shift value.
   assign w_complete  = s_valid && (r_cnt == CW'(WIDTH - 1));
   assign w_slot_free = !r_pvalid || p_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sh     <= '0;
         r_cnt    <= '0;
         r_pout   <= '0;
         r_pvalid <= 1'b0;
         r_ovr    <= 1'b0;
      end else begin
         if (s_valid) begin
            r_sh  <= w_sh_next;
            r_cnt <= w_complete ? '0 : r_cnt + CW'(1);
         end
         if (w_complete && w_slot_free) begin
            r_pout   <= w_sh_next;
            r_pvalid <= 1'b1;
         end else if (w_complete) begin
            r_ovr <= 1'b1;
         end else if (r_pvalid && p_ready) begin
            r_pvalid <= 1'b0;
         end
      end
   end

   assign p_out   = r_pout;
   assign p_valid = r_pvalid;
   assign busy    = (r_cnt != '0);
   assign overrun = r_ovr;

endmodule
